// File: rtl/insn_encoder.sv
// Symbolic instruction request -> 32-bit ISA word encoder with a show-ahead FIFO
// that streams words at consecutive imem addresses. Optional macro: IMM_RANGE_CHECK_EN.
module insn_encoder #(
    parameter int DEPTH     = 8,
    parameter int ADDR_W    = 12,
    parameter int BASE_ADDR = 0
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [4:0]                 in_kind,
    input  logic [4:0]                 in_rd,
    input  logic [4:0]                 in_rs,
    input  logic [4:0]                 in_rt,
    input  logic [4:0]                 in_shamt,
    input  logic [26:0]                in_imm,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_insn,
    output logic [ADDR_W-1:0]          out_addr,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       err,
    input  logic                       clr_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    function automatic logic [4:0] opcode_of(input logic [4:0] kind);
        case (kind)
            5'd8:    opcode_of = 5'b00001;
            5'd9:    opcode_of = 5'b00010;
            5'd10:   opcode_of = 5'b00011;
            5'd11:   opcode_of = 5'b00100;
            5'd12:   opcode_of = 5'b00101;
            5'd13:   opcode_of = 5'b00110;
            5'd14:   opcode_of = 5'b00111;
            5'd15:   opcode_of = 5'b01000;
            5'd16:   opcode_of = 5'b10101;
            5'd17:   opcode_of = 5'b10110;
            default: opcode_of = 5'b00000;
        endcase
    endfunction

    // Returns {legal, word}; unused request fields never reach the word.
    function automatic logic [32:0] encode(input logic [4:0] kind, input logic [4:0] rd,
                                           input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] shamt, input logic [26:0] imm);
        logic [32:0] r;
        r = {1'b1, 32'h0000_0000};
        case (kind) inside
            [5'd0:5'd7]: r[31:0] = {5'b00000, rd, rs, rt, shamt, kind, 2'b00};
            5'd9, 5'd12, 5'd13, 5'd14, 5'd15: begin
                r[31:0] = {opcode_of(kind), rd, rs, imm[16:0]};
`ifdef IMM_RANGE_CHECK_EN
                r[32] = (imm[26:17] == {10{imm[16]}});
`endif
            end
            5'd11:       r[31:0] = {opcode_of(kind), rd, 22'd0};
            5'd8, 5'd10, 5'd16, 5'd17: r[31:0] = {opcode_of(kind), imm};
            default:     r[32] = 1'b0;
        endcase
        return r;
    endfunction

    logic [31:0]       mem_q [DEPTH];
    logic [31:0]       mem_d [DEPTH];
    logic [PW-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic [LW-1:0]     level_q, level_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              err_q, err_d;
    logic              acc_s, push_s, pop_s, legal_s;
    logic [31:0]       word_s;

    // Next-state: encode on accept, push legal words, pop on output handshake.
    always_comb begin
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        addr_d  = addr_q;
        level_d = level_q;
        {legal_s, word_s} = encode(in_kind, in_rd, in_rs, in_rt, in_shamt, in_imm);
        acc_s   = in_valid && (level_q != LW'(DEPTH));
        push_s  = acc_s && legal_s;
        pop_s   = (level_q != LW'(0)) && out_ready;
        if (push_s) begin
            mem_d[wr_q] = word_s;
            wr_d        = wr_q + PW'(1);
        end else begin
            wr_d = wr_q;
        end
        if (pop_s) begin
            rd_d   = rd_q + PW'(1);
            addr_d = addr_q + ADDR_W'(1);
        end else begin
            rd_d = rd_q;
        end
        case ({push_s, pop_s})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        // A fresh error wins over a simultaneous clear.
        if (acc_s && !legal_s) begin
            err_d = 1'b1;
        end else if (clr_err) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // State registers with asynchronous reset that discards all buffered words.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'h0000_0000;
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
            addr_q  <= ADDR_W'(BASE_ADDR);
            err_q   <= 1'b0;
        end else begin
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
        end
    end

    assign in_ready  = (level_q != LW'(DEPTH));
    assign out_valid = (level_q != LW'(0));
    assign out_insn  = out_valid ? mem_q[rd_q] : 32'h0000_0000;
    assign out_addr  = addr_q;
    assign level     = level_q;
    assign err       = err_q;

endmodule
